// File: rtl/lfsr_checker.sv
// Locks onto an 8-bit LFSR byte stream (x^8+x^4+x^3+x^2+1, extended to period 256)
// and counts mismatches once locked. Outputs are registered one cycle after each sample.
module lfsr_checker #(
    parameter int unsigned LOCK_COUNT   = 5,
    parameter int unsigned UNLOCK_COUNT = 3,
    parameter int unsigned ERR_W        = 16
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [7:0]       i_lfsr,
    input  logic             i_clear,
    output logic             o_lock,
    output logic             o_err,
    output logic [ERR_W-1:0] o_err_count
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int NW = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic [1:0] {UNLOCKED, SEARCH, LOCKED} state_t;

    // Extra 0x00 state is entered from 0x80 and leaves to 0x1D, giving a full 256 period.
    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        logic fb;
        fb = x[7] ^ (x[6:0] == 7'd0);
        return {x[6:0], 1'b0} ^ {3'b000, fb, fb, fb, 1'b0, fb};
    endfunction

    state_t           state_q;
    logic [7:0]       ref_q;
    logic [MW-1:0]    match_q;
    logic [NW-1:0]    miss_q;
    logic             lock_q;
    logic             err_q;
    logic [ERR_W-1:0] cnt_q;

    logic       hit_d;
    logic [7:0] ref_d;

    assign hit_d = (i_lfsr == ref_q);
    // Locked mode free-runs the reference; otherwise it re-seeds from the sample.
    assign ref_d = (state_q == LOCKED) ? lfsr_next(ref_q) : lfsr_next(i_lfsr);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= UNLOCKED;
            ref_q   <= 8'h00;
            match_q <= '0;
            miss_q  <= '0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_q <= 1'b0;
            if (i_clear) cnt_q <= '0;
            if (i_valid) begin
                ref_q <= ref_d;
                case (state_q)
                    UNLOCKED: begin
                        match_q <= '0;
                        state_q <= SEARCH;
                    end
                    SEARCH: begin
                        if (hit_d) begin
                            match_q <= match_q + 1'b1;
                            if (match_q == MW'(LOCK_COUNT - 1)) begin
                                state_q <= LOCKED;
                                lock_q  <= 1'b1;
                                miss_q  <= '0;
                            end
                        end else begin
                            match_q <= '0;
                        end
                    end
                    LOCKED: begin
                        if (hit_d) begin
                            miss_q <= '0;
                        end else begin
                            err_q  <= 1'b1;
                            miss_q <= miss_q + 1'b1;
                            if (!i_clear && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                            if (miss_q == NW'(UNLOCK_COUNT - 1)) begin
                                state_q <= UNLOCKED;
                                lock_q  <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= UNLOCKED;
                endcase
            end
        end
    end

    assign o_lock      = lock_q;
    assign o_err       = err_q;
    assign o_err_count = cnt_q;

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 The block SHALL have parameter LOCK_COUNT, default 5, giving the consecutive matching samples needed to declare lock.
REQ-002 The block SHALL have parameter UNLOCK_COUNT, default 3, giving the consecutive mismatching samples that drop lock.
REQ-003 The block SHALL have parameter ERR_W, default 16, giving the width of the error counter.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_valid  input  1  qualifies i_lfsr; the sample is consumed on a rising edge with i_valid=1.
REQ-007 i_lfsr  input  8  received sequence byte from the upstream 8-bit LFSR generator.
REQ-008 i_clear  input  1  synchronous clear of the error counter.
REQ-009 o_lock  output  1  high while state is LOCKED.
REQ-010 o_err  output  1  one-cycle pulse per mismatching sample in LOCKED.
REQ-011 o_err_count  output  ERR_W  saturating count of mismatching samples in LOCKED.

Function
REQ-012 NEXT(x) SHALL be: fb = x[7] XOR (x[6:0]==0); y[0]=fb, y[1]=x[0], y[2]=x[1]^fb, y[3]=x[2]^fb, y[4]=x[3]^fb, y[5]=x[4], y[6]=x[5], y[7]=x[6]; period 256, including 0x00.
REQ-013 With i_valid=0, state, reference register, match/miss counters and o_err_count SHALL hold, and o_err SHALL be 0 on the following cycle.
REQ-014 States SHALL be UNLOCKED, SEARCH, LOCKED; an 8-bit reference register ref holds the expected next sample.
REQ-015 UNLOCKED, valid sample s: ref <= NEXT(s), match_cnt <= 0, go to SEARCH.
REQ-016 SEARCH, valid s == ref: ref <= NEXT(s), match_cnt +1; when match_cnt+1 == LOCK_COUNT go to LOCKED, miss_cnt <= 0.
REQ-017 SEARCH, valid s != ref: ref <= NEXT(s), match_cnt <= 0, remain in SEARCH; no error counted.
REQ-018 LOCKED, every valid sample: ref <= NEXT(ref) (free-running, never reloaded from s).
REQ-019 LOCKED, valid s == ref: miss_cnt <= 0.
REQ-020 LOCKED, valid s != ref: o_err=1 for exactly the next cycle, o_err_count +1 saturating at 2^ERR_W-1, miss_cnt +1; when miss_cnt+1 == UNLOCK_COUNT go to UNLOCKED.
REQ-021 o_lock, o_err and o_err_count SHALL be registered; each reflects a sample one cycle after the edge that consumes it.
REQ-022 i_clear=1 SHALL set o_err_count to 0 at the next edge, winning over a simultaneous increment; o_err still pulses for that mismatch; state and ref unaffected.
REQ-023 Back-to-back valid samples on consecutive cycles SHALL be processed without loss; consecutive mismatches give consecutive o_err pulses.

Reset
REQ-024 i_rst=1 SHALL immediately force state UNLOCKED, ref=0x00, match_cnt=0, miss_cnt=0, o_lock=0, o_err=0, o_err_count=0, including mid-LOCKED.
REQ-025 After i_rst deasserts, the first valid sample SHALL be treated as in UNLOCKED.

Verification
REQ-026 Reset, then valid samples 0x01,0x02,0x04,0x08,0x10,0x20 on consecutive cycles -> o_lock rises the cycle after 0x20 is consumed; o_err never asserts; o_err_count=0.
REQ-027 Locked after REQ-026, feed 0x40,0x80,0x00,0x1D -> no errors; wrap through 0x80->0x00->0x1D is accepted.
REQ-028 Locked, feed 0x40, 0xFF (expected 0x80), 0x00 -> exactly one o_err pulse, o_err_count=1, o_lock stays 1, 0x00 matches.
REQ-029 Locked, three consecutive samples 0xAA -> three o_err pulses, o_err_count=3, o_lock falls after the third; a further six correct samples relock.
REQ-030 Locked, i_valid low 4 cycles mid-sequence with i_lfsr toggling randomly -> no state change, no o_err; sequence resumes with no error; i_clear with a simultaneous mismatch -> o_err_count=0, o_err=1.
REQ-031 i_rst pulsed mid-LOCKED between clock edges with o_err_count=5 -> o_lock, o_err, o_err_count go to 0 without a clock edge.
